// File: rtl/l2_pkg.sv
// l2_pkg: shared definitions for the L2 block responder.
//   - state encoding constants (IDLE, WB, ALLOC, RESP, GAP)
//   - BLOCK_W / ADDR_W widths of the 128-bit block protocol
//   - tag_width(): tag bits left after the index is taken from a block address
package l2_pkg;

    localparam int BLOCK_W = 128;
    localparam int ADDR_W  = 28;

    // Plain 3-bit constants so the state can be probed from older tooling.
    typedef logic [2:0] l2_state_t;
    localparam l2_state_t ST_IDLE  = 3'd0;
    localparam l2_state_t ST_WB    = 3'd1;
    localparam l2_state_t ST_ALLOC = 3'd2;
    localparam l2_state_t ST_RESP  = 3'd3;
    localparam l2_state_t ST_GAP   = 3'd4;

    function automatic int tag_width(input int index_w);
        return ADDR_W - index_w;
    endfunction

endpackage

// File: rtl/l2_tag_array.sv
// l2_tag_array: valid / dirty / tag storage for a direct-mapped L2.
// Ports:
//   clk, proc_reset_n       clock, synchronous active-low reset (clears valid+dirty)
//   index, lookup_tag       line select and tag to compare against
//   hit                     selected line valid and tag equal
//   victim_valid/dirty/tag  current contents of the selected line
//   install_en/dirty/tag    write the selected line (valid=1, dirty, tag)
//   clear_dirty             clear dirty of the selected line (install wins)
module l2_tag_array
    import l2_pkg::*;
#(
    parameter int NUM_OF_BLOCK = 64,
    parameter int INDEX_W      = 6
) (
    input  logic                          clk,
    input  logic                          proc_reset_n,
    input  logic [INDEX_W-1:0]            index,
    input  logic [tag_width(INDEX_W)-1:0] lookup_tag,
    output logic                          hit,
    output logic                          victim_valid,
    output logic                          victim_dirty,
    output logic [tag_width(INDEX_W)-1:0] victim_tag,
    input  logic                          install_en,
    input  logic                          install_dirty,
    input  logic [tag_width(INDEX_W)-1:0] install_tag,
    input  logic                          clear_dirty
);

    localparam int TAG_W = tag_width(INDEX_W);

    logic [NUM_OF_BLOCK-1:0] valid_reg;
    logic [NUM_OF_BLOCK-1:0] dirty_reg;
    logic [TAG_W-1:0]        tag_reg [NUM_OF_BLOCK];

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (install_en) begin
            valid_reg[index] <= 1'b1;
            dirty_reg[index] <= install_dirty;
        end else if (clear_dirty) begin
            dirty_reg[index] <= 1'b0;
        end
    end

    // Tags need no reset: they are meaningless while valid is clear.
    always_ff @(posedge clk) begin
        if (install_en) begin
            tag_reg[index] <= install_tag;
        end
    end

    assign victim_valid = valid_reg[index];
    assign victim_dirty = dirty_reg[index];
    assign victim_tag   = tag_reg[index];
    assign hit          = victim_valid && (victim_tag == lookup_tag);

endmodule

// File: rtl/l2_block_responder.sv
// l2_block_responder: direct-mapped, write-back unified L2 cache.
// Responds to L1 block requests and initiates block transfers to memory.
// Ports:
//   clk, proc_reset_n               clock, synchronous active-low reset
//   l1_read, l1_write, l1_addr,
//   l1_wdata                        L1 request (held until l1_ready)
//   l1_rdata, l1_ready              L1 response (one-cycle ready pulse)
//   mem_read, mem_write, mem_addr,
//   mem_wdata                       memory request (held until mem_ready)
//   mem_rdata, mem_ready            memory response
//   hit_cnt, miss_cnt, wb_cnt       saturating statistics, only when
//                                   L2_STATS_EN is defined
module l2_block_responder
    import l2_pkg::*;
#(
    parameter int NUM_OF_BLOCK = 64,
    parameter int INDEX_W      = 6
) (
    input  logic               clk,
    input  logic               proc_reset_n,
    input  logic               l1_read,
    input  logic               l1_write,
    input  logic [ADDR_W-1:0]  l1_addr,
    input  logic [BLOCK_W-1:0] l1_wdata,
    output logic [BLOCK_W-1:0] l1_rdata,
    output logic               l1_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
`ifdef L2_STATS_EN
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt,
    output logic [31:0]        wb_cnt,
`endif
    input  logic               mem_ready
);

    localparam int TAG_W = tag_width(INDEX_W);

    l2_state_t          state_reg, state_next;
    logic [BLOCK_W-1:0] rdata_reg, rdata_next;
    logic [BLOCK_W-1:0] data_array [NUM_OF_BLOCK];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               req;
    logic               hit;
    logic               victim_valid;
    logic               victim_dirty;
    logic [TAG_W-1:0]   victim_tag;
    logic               install_en;
    logic               install_dirty;
    logic               clear_dirty;
    logic               data_we;
    logic [BLOCK_W-1:0] data_wdata;
    logic [BLOCK_W-1:0] line_data;

    assign index     = l1_addr[INDEX_W-1:0];
    assign tag       = l1_addr[ADDR_W-1:INDEX_W];
    assign req       = l1_read || l1_write;
    assign line_data = data_array[index];

    l2_tag_array #(
        .NUM_OF_BLOCK (NUM_OF_BLOCK),
        .INDEX_W      (INDEX_W)
    ) u_tags (
        .clk           (clk),
        .proc_reset_n  (proc_reset_n),
        .index         (index),
        .lookup_tag    (tag),
        .hit           (hit),
        .victim_valid  (victim_valid),
        .victim_dirty  (victim_dirty),
        .victim_tag    (victim_tag),
        .install_en    (install_en),
        .install_dirty (install_dirty),
        .install_tag   (tag),
        .clear_dirty   (clear_dirty)
    );

    // A write (including read+write together) always takes the write path.
    // Write misses install without a fetch since the whole block is supplied.
    always_comb begin
        state_next    = state_reg;
        rdata_next    = rdata_reg;
        install_en    = 1'b0;
        install_dirty = 1'b0;
        clear_dirty   = 1'b0;
        data_we       = 1'b0;
        data_wdata    = l1_wdata;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    if (hit && !l1_write) begin
                        rdata_next = line_data;
                        state_next = ST_RESP;
                    end else if (hit || !(victim_valid && victim_dirty)) begin
                        if (l1_write) begin
                            install_en    = 1'b1;
                            install_dirty = 1'b1;
                            data_we       = 1'b1;
                            state_next    = ST_RESP;
                        end else begin
                            state_next = ST_ALLOC;
                        end
                    end else begin
                        state_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                if (mem_ready) begin
                    clear_dirty = 1'b1;
                    if (l1_write) begin
                        install_en    = 1'b1;
                        install_dirty = 1'b1;
                        data_we       = 1'b1;
                        state_next    = ST_RESP;
                    end else begin
                        state_next = ST_ALLOC;
                    end
                end
            end
            ST_ALLOC: begin
                if (mem_ready) begin
                    install_en = 1'b1;
                    data_we    = 1'b1;
                    data_wdata = mem_rdata;
                    rdata_next = mem_rdata;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_GAP;
            ST_GAP: begin
                // L1 drops its request a cycle late; ignore it here.
                rdata_next = '0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            state_reg <= ST_IDLE;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            rdata_reg <= rdata_next;
        end
    end

    // Data storage has no reset; contents are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_array[index] <= data_wdata;
        end
    end

    assign l1_ready  = (state_reg == ST_RESP);
    assign l1_rdata  = rdata_reg;
    assign mem_write = (state_reg == ST_WB);
    assign mem_read  = (state_reg == ST_ALLOC);
    assign mem_addr  = mem_write ? {victim_tag, index} :
                       mem_read  ? l1_addr : '0;
    assign mem_wdata = mem_write ? line_data : '0;

`ifdef L2_STATS_EN
    logic        hit_evt, miss_evt, wb_evt;
    logic [31:0] hit_cnt_reg, miss_cnt_reg, wb_cnt_reg;

    assign hit_evt  = (state_reg == ST_IDLE) && req && hit;
    assign miss_evt = (state_reg == ST_IDLE) && req && !hit;
    assign wb_evt   = (state_reg == ST_WB) && mem_ready;

    always_ff @(posedge clk) begin
        if (!proc_reset_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            wb_cnt_reg   <= '0;
        end else begin
            if (hit_evt && (hit_cnt_reg != '1)) hit_cnt_reg <= hit_cnt_reg + 32'd1;
            if (miss_evt && (miss_cnt_reg != '1)) miss_cnt_reg <= miss_cnt_reg + 32'd1;
            if (wb_evt && (wb_cnt_reg != '1)) wb_cnt_reg <= wb_cnt_reg + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
    assign wb_cnt   = wb_cnt_reg;
`endif

    a_l1_req_exclusive: assert property (@(posedge clk) disable iff (!proc_reset_n)
        !(l1_read && l1_write));
    a_mem_req_exclusive: assert property (@(posedge clk) disable iff (!proc_reset_n)
        !(mem_read && mem_write));

endmodule

// File: tb/tb_l2_block_responder.sv
// tb_l2_block_responder: directed bench for l2_block_responder.
// A transaction-level cache model predicts, per L1 request, the memory
// transfers (write-back, fetch), the returned block and the response
// latency; a memory responder logs what the DUT actually issues.
module tb_l2_block_responder;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         l1_read, l1_write;
    logic [27:0]  l1_addr;
    logic [127:0] l1_wdata, l1_rdata;
    logic         l1_ready;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
`ifdef L2_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

    l2_block_responder dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .l1_read      (l1_read),
        .l1_write     (l1_write),
        .l1_addr      (l1_addr),
        .l1_wdata     (l1_wdata),
        .l1_rdata     (l1_rdata),
        .l1_ready     (l1_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
`ifdef L2_STATS_EN
        .hit_cnt      (hit_cnt),
        .miss_cnt     (miss_cnt),
        .wb_cnt       (wb_cnt),
`endif
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [127:0] act,
                                  input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic         wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } mem_txn_t;

    // ---------------- memory model + responder ----------------
    localparam int MEM_LAT = 3;
    logic [127:0] mem_model [logic [27:0]];
    mem_txn_t     log_q[$];
    int           last_mem_ready_cyc = 0;

    function automatic logic [127:0] mem_get(input logic [27:0] a);
        logic [31:0] w;
        if (mem_model.exists(a)) return mem_model[a];
        w = 32'hA5A50000 + {4'h0, a};
        return {w, w, w, w};
    endfunction

    initial begin : responder
        mem_txn_t t;
        bit       aborted;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (proc_reset_n && (mem_read || mem_write)) begin
                t.wr   = mem_write;
                t.addr = mem_addr;
                t.data = mem_write ? mem_wdata : 128'h0;
                log_q.push_back(t);
                aborted = 1'b0;
                for (int i = 0; i < MEM_LAT - 1; i++) begin
                    @(negedge clk);
                    if (!proc_reset_n || !(mem_read || mem_write)) aborted = 1'b1;
                end
                if (!aborted) begin
                    if (t.wr) mem_model[t.addr] = t.data;
                    else      mem_rdata = mem_get(t.addr);
                    mem_ready = 1'b1;
                    last_mem_ready_cyc = cyc;
                    @(negedge clk);
                    mem_ready = 1'b0;
                    mem_rdata = '0;
                end
            end
        end
    end

    // ---------------- cache model ----------------
    logic         m_valid [64];
    logic         m_dirty [64];
    logic [21:0]  m_tag   [64];
    logic [127:0] m_data  [64];

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic         exp_rd_check = 1'b0;
    logic [127:0] exp_rdata = '0;
    int           ready_pulses = 0;

    always @(negedge clk) begin
        if (proc_reset_n) begin
            if (mem_read || mem_write) check("mem_rd_wr_exclusive", mem_read & mem_write, 0);
            if (l1_ready) begin
                ready_pulses++;
                if (exp_rd_check) check("l1_rdata", l1_rdata, exp_rdata);
            end
        end
    end

    // ---------------- L1 transaction driver ----------------
    int           exp_ready_total = 0;
    logic [127:0] last_rdata;

    task automatic l1_txn(input bit wr, input logic [27:0] addr,
                          input logic [127:0] wdata, input int hold_extra,
                          input string name);
        mem_txn_t    exp_q[$];
        mem_txn_t    e;
        logic [5:0]  idx;
        logic [21:0] tg;
        bit          hit, seen;
        int          req_cyc, rdy_cyc;
        idx = addr[5:0];
        tg  = addr[27:6];
        hit = m_valid[idx] && (m_tag[idx] == tg);
        if (!hit && m_valid[idx] && m_dirty[idx]) begin
            e.wr = 1'b1; e.addr = {m_tag[idx], idx}; e.data = m_data[idx];
            exp_q.push_back(e);
        end
        if (!hit && !wr) begin
            e.wr = 1'b0; e.addr = addr; e.data = '0;
            exp_q.push_back(e);
        end
        if (wr) begin
            m_data[idx] = wdata; m_dirty[idx] = 1'b1;
        end else if (!hit) begin
            m_data[idx] = mem_get(addr); m_dirty[idx] = 1'b0;
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        exp_rdata    = m_data[idx];
        exp_rd_check = !wr;
        exp_ready_total++;
        log_q.delete();

        l1_read  = !wr;
        l1_write = wr;
        l1_addr  = addr;
        l1_wdata = wdata;
        req_cyc  = cyc;
        seen     = 1'b0;
        rdy_cyc  = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (l1_ready) begin
                seen = 1'b1;
                rdy_cyc = cyc;
                last_rdata = l1_rdata;
            end
        end
        if (!seen) check({name, "_ready_timeout"}, 0, 1);
        else if (exp_q.size() == 0) check({name, "_hit_latency"}, rdy_cyc - req_cyc, 1);
        else check({name, "_miss_latency"}, rdy_cyc - last_mem_ready_cyc, 1);
        repeat (hold_extra) @(negedge clk);
        l1_read  = 1'b0;
        l1_write = 1'b0;
        repeat (4) @(negedge clk);
        exp_rd_check = 1'b0;

        check({name, "_mem_txn_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check({name, "_mem_txn_wr"}, log_q[i].wr, exp_q[i].wr);
            check({name, "_mem_txn_addr"}, log_q[i].addr, exp_q[i].addr);
            check({name, "_mem_txn_data"}, log_q[i].data, exp_q[i].data);
        end
        check({name, "_ready_pulses"}, ready_pulses, exp_ready_total);
        $display("txn %s wr=%0d addr=%h mem_txns=%0d rdata=%h", name, wr, addr,
                 log_q.size(), last_rdata);
    endtask

    // ---------------- directed sequence ----------------
    localparam logic [127:0] BLK_A   = 128'hA5A50010_A5A50010_A5A50010_A5A50010;
    localparam logic [127:0] BLK_50  = 128'hA5A50050_A5A50050_A5A50050_A5A50050;
    localparam logic [127:0] BLK_B   = 128'h0B0B0B0B_11112222_33334444_55556666;
    localparam logic [127:0] BLK_C   = 128'hC0C0C0C0_DEADBEEF_01234567_89ABCDEF;

    initial begin : main
        bit got;
        proc_reset_n = 1'b0;
        l1_read = 1'b0; l1_write = 1'b0; l1_addr = '0; l1_wdata = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_l1_ready", l1_ready, 0);
        check("reset_l1_rdata", l1_rdata, 0);
        check("reset_mem_read", mem_read, 0);
        check("reset_mem_write", mem_write, 0);
        check("reset_mem_addr", mem_addr, 0);
        check("reset_mem_wdata", mem_wdata, 0);
        proc_reset_n = 1'b1;
        @(negedge clk);

        // 1: cold read
        l1_txn(1'b0, 28'h0000010, '0, 0, "cold_read");
        check("cold_read_rdata_lit", last_rdata, BLK_A);
        check("cold_read_addr_lit", log_q.size() > 0 ? log_q[0].addr : 28'hFFFFFFF, 28'h0000010);

        // 2: read hit
        l1_txn(1'b0, 28'h0000010, '0, 0, "read_hit");
        check("read_hit_rdata_lit", last_rdata, BLK_A);

        // 3: write hit, then conflicting read forces write-back
        l1_txn(1'b1, 28'h0000010, BLK_B, 0, "write_hit");
        l1_txn(1'b0, 28'h0000050, '0, 0, "conflict_read");
        check("conflict_wb_data_lit", log_q.size() > 0 ? log_q[0].data : 128'h0, BLK_B);
        check("conflict_rdata_lit", last_rdata, BLK_50);

        // 4: L1 keeps the request two cycles past ready
        l1_txn(1'b0, 28'h0000050, '0, 2, "late_drop");
        l1_txn(1'b0, 28'h0000010, '0, 0, "fresh_after_late");
        check("fresh_wb_none_clean", log_q.size(), 1);

        // 5: write miss to an invalid line, then read it back
        l1_txn(1'b1, 28'h0000123, BLK_C, 0, "write_miss");
        l1_txn(1'b0, 28'h0000123, '0, 0, "read_back");
        check("read_back_rdata_lit", last_rdata, BLK_C);

        // 6: reset while a fetch is outstanding
        l1_addr = 28'h0000777;
        l1_read = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_read) got = 1'b1;
        end
        check("alloc_reached", got, 1);
        proc_reset_n = 1'b0;
        l1_read = 1'b0;
        @(negedge clk);
        check("mid_reset_mem_read", mem_read, 0);
        check("mid_reset_l1_ready", l1_ready, 0);
        proc_reset_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        l1_txn(1'b0, 28'h0000777, '0, 0, "after_reset_read");
        check("after_reset_fetch_lit", log_q.size() > 0 ? log_q[0].addr : 28'h0, 28'h0000777);
        l1_txn(1'b0, 28'h0000123, '0, 0, "after_reset_lost_line");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
